play_core: RTL and testbench

Playback engine, the read-side counterpart of the recording core. On `play_start` it reads the length word stored at the base address in SDRAM, then fetches samples `base+1 … base+N` one word at a time and presents each to the audio output path over a valid/ready handshake. It sits between the top-level controller, the SDRAM arbiter port and the audio DAC interface. It supports pause, stop and optional looping.

---
 rtl/play_core.sv | 168 ++++++++++++++++
 tb/tb_play_core.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/play_core.sv
// Playback engine: reads a length word at play_base, then streams samples base+1..base+N to the DAC path.
// Optional build macro PLAY_LOOP_EN restarts from base+1 after the last sample until play_stop.
module play_core (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        play_start,
    input  logic [22:0] play_base,
    input  logic        play_pause,
    input  logic        play_stop,
    output logic        play_done,
    output logic        play_read,
    output logic [22:0] play_addr,
    input  logic [31:0] play_readdata,
    output logic        play_write,
    output logic [31:0] play_writedata,
    input  logic        play_sdram_finished,
    output logic [31:0] play_audio_data,
    output logic        play_audio_valid,
    input  logic        play_audio_ready
);

    // state    | meaning
    // IDLE     | waiting for play_start, tracking play_base
    // READ_LEN | reading the length word at base
    // FETCH    | reading the next sample (request held back while paused)
    // OUTPUT   | presenting the sample until the DAC path accepts it
    // DRAIN    | stopped mid-read, waiting for the SDRAM to finish
    typedef enum logic [2:0] {
        IDLE,
        READ_LEN,
        FETCH,
        OUTPUT,
        DRAIN
    } state_t;

    state_t      state;
    logic [22:0] addr;
    logic [22:0] base_q;
    logic [22:0] remaining;
    logic [31:0] sample;
    logic        read_q;
    logic        fin;
    logic        done_c;
`ifdef PLAY_LOOP_EN
    logic [22:0] len_q;
`endif

    // A finish only counts against a request we actually have outstanding.
    assign fin = read_q && play_sdram_finished;

    assign play_read        = read_q;
    assign play_addr        = addr;
    assign play_audio_valid = (state == OUTPUT);
    assign play_audio_data  = sample;
    assign play_write       = 1'b0;
    assign play_writedata   = 32'h0;
    assign play_done        = done_c && i_rst_n;

    always_comb begin
        done_c = 1'b0;
        case (state)
            READ_LEN: done_c = fin && (play_stop || (play_readdata[22:0] == 23'h0));
            FETCH:    done_c = play_stop && (fin || !read_q);
            OUTPUT: begin
                if (play_stop)
                    done_c = 1'b1;
`ifndef PLAY_LOOP_EN
                else if (play_audio_ready && (remaining == 23'h0))
                    done_c = 1'b1;
`endif
            end
            DRAIN:    done_c = fin;
            default:  done_c = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            addr      <= 23'h0;
            base_q    <= 23'h0;
            remaining <= 23'h0;
            sample    <= 32'h0;
            read_q    <= 1'b0;
`ifdef PLAY_LOOP_EN
            len_q     <= 23'h0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    addr   <= play_base;
                    base_q <= play_base;
                    if (play_start) begin
                        state  <= READ_LEN;
                        read_q <= 1'b1;
                    end
                end
                READ_LEN: begin
                    if (fin) begin
                        read_q    <= 1'b0;
                        remaining <= play_readdata[22:0];
                        addr      <= base_q + 23'd1;
`ifdef PLAY_LOOP_EN
                        len_q     <= play_readdata[22:0];
`endif
                        if (play_stop || (play_readdata[22:0] == 23'h0)) begin
                            state <= IDLE;
                        end else begin
                            state  <= FETCH;
                            read_q <= !play_pause;
                        end
                    end else if (play_stop) begin
                        state <= DRAIN;
                    end
                end
                FETCH: begin
                    // A stop while paused has no transaction to wait for.
                    if (play_stop) begin
                        if (fin || !read_q) begin
                            state  <= IDLE;
                            read_q <= 1'b0;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (fin) begin
                        sample    <= play_readdata;
                        addr      <= addr + 23'd1;
                        remaining <= remaining - 23'd1;
                        read_q    <= 1'b0;
                        state     <= OUTPUT;
                    end else if (!read_q && !play_pause) begin
                        read_q <= 1'b1;
                    end
                end
                OUTPUT: begin
                    if (play_stop) begin
                        state <= IDLE;
                    end else if (play_audio_ready) begin
                        if (remaining == 23'h0) begin
`ifdef PLAY_LOOP_EN
                            addr      <= base_q + 23'd1;
                            remaining <= len_q;
                            state     <= FETCH;
                            read_q    <= !play_pause;
`else
                            state     <= IDLE;
`endif
                        end else begin
                            state  <= FETCH;
                            read_q <= !play_pause;
                        end
                    end
                end
                DRAIN: begin
                    if (fin) begin
                        read_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    read_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_play_core.sv
// Testbench for play_core: SDRAM model with random latency, expected read/sample queues, directed corner cases.
module tb_play_core;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        play_start = 1'b0;
    logic [22:0] play_base = 23'h0;
    logic        play_pause = 1'b0;
    logic        play_stop = 1'b0;
    logic        play_audio_ready = 1'b0;
    logic        play_done;
    logic        play_read;
    logic [22:0] play_addr;
    logic [31:0] play_readdata;
    logic        play_write;
    logic [31:0] play_writedata;
    logic        play_sdram_finished;
    logic [31:0] play_audio_data;
    logic        play_audio_valid;

    play_core dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .play_start(play_start), .play_base(play_base),
        .play_pause(play_pause), .play_stop(play_stop),
        .play_done(play_done), .play_read(play_read), .play_addr(play_addr),
        .play_readdata(play_readdata), .play_write(play_write),
        .play_writedata(play_writedata), .play_sdram_finished(play_sdram_finished),
        .play_audio_data(play_audio_data), .play_audio_valid(play_audio_valid),
        .play_audio_ready(play_audio_ready)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int failures = 0;

    // SDRAM model: each request completes after lat_cur extra wait cycles.
    logic [31:0] mem [logic [22:0]];
    int wait_cnt = 0;
    int lat_cur = 0;
    int force_lat = -1;

    assign play_sdram_finished = play_read && (wait_cnt == lat_cur);

    always_comb begin
        play_readdata = 32'h0;
        if (play_sdram_finished && mem.exists(play_addr))
            play_readdata = mem[play_addr];
    end

    always @(posedge i_clk) begin
        if (!i_rst_n || !play_read || play_sdram_finished)
            wait_cnt <= 0;
        else
            wait_cnt <= wait_cnt + 1;
        if (!play_read || play_sdram_finished)
            lat_cur <= (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
    end

    // Expected behaviour, built from the playback rules
    logic [22:0] q_addr [$];
    logic [31:0] q_samp [$];
    int rd_cyc = 0, vld_cnt = 0, done_cnt = 0;
    logic prev_pend = 1'b0, prev_hold = 1'b0, prev_done = 1'b0;
    logic [22:0] prev_addr = 23'h0;
    logic [31:0] prev_data = 32'h0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic monitor();
        if (!i_rst_n) begin
            prev_pend = 1'b0;
            prev_hold = 1'b0;
            prev_done = 1'b0;
            return;
        end
        if (prev_pend)
            check("rd_hold", 64'({play_read, play_addr}), 64'({1'b1, prev_addr}));
        if (prev_hold)
            check("vld_hold", 64'({play_audio_valid, play_audio_data}), 64'({1'b1, prev_data}));
        if (prev_done)
            check("post_done_idle", 64'({play_read, play_audio_valid, play_done}), 64'(0));
        if (play_read) rd_cyc++;
        if (play_audio_valid) vld_cnt++;
        if (play_done) done_cnt++;
        if (play_sdram_finished) begin
            check("rd_expected", 64'(q_addr.size() > 0), 64'(1));
            if (q_addr.size() > 0) check("rd_addr", 64'(play_addr), 64'(q_addr.pop_front()));
        end
        if (play_audio_valid && play_audio_ready) begin
            check("samp_expected", 64'(q_samp.size() > 0), 64'(1));
            if (q_samp.size() > 0) check("sample", 64'(play_audio_data), 64'(q_samp.pop_front()));
        end
        prev_pend = play_read && !play_sdram_finished;
        prev_addr = play_addr;
        prev_hold = play_audio_valid && !play_audio_ready && !play_stop;
        prev_data = play_audio_data;
        prev_done = play_done;
    endtask

    task automatic tick();
        @(negedge i_clk);
        monitor();
        @(posedge i_clk);
        #1;
    endtask

    task automatic load(input logic [22:0] base, input int len, input int passes);
        logic [22:0] a;
        mem.delete();
        q_addr.delete();
        q_samp.delete();
        mem[base] = {9'($urandom), 23'(len)};
        q_addr.push_back(base);
        for (int i = 1; i <= len; i++) begin
            a = base + 23'(i);
            mem[a] = $urandom;
        end
        for (int p = 0; p < passes; p++)
            for (int i = 1; i <= len; i++) begin
                a = base + 23'(i);
                q_addr.push_back(a);
                q_samp.push_back(mem[a]);
            end
        done_cnt = 0;
        vld_cnt = 0;
    endtask

    task automatic start(input logic [22:0] base);
        play_base = base;
        play_start = 1'b1;
        tick();
        play_start = 1'b0;
    endtask

    task automatic finish_checks(input string tag);
        check({tag, "_done"}, 64'(done_cnt), 64'(1));
        check({tag, "_addr_left"}, 64'(q_addr.size()), 64'(0));
        check({tag, "_samp_left"}, 64'(q_samp.size()), 64'(0));
    endtask

    task automatic run_play(input logic [22:0] base, input int len, input int lat,
                            input int rdy_pct, input int pause_pct, output int cyc);
        load(base, len, 1);
        force_lat = lat;
        start(base);
        cyc = 0;
        while (cyc < 3000 && done_cnt == 0) begin
            play_audio_ready = ($urandom_range(99) < rdy_pct);
            play_pause = ($urandom_range(99) < pause_pct);
            tick();
            cyc++;
        end
        play_pause = 1'b0;
        play_audio_ready = 1'b0;
        finish_checks("run");
        if (len == 0) check("len0_no_valid", 64'(vld_cnt), 64'(0));
        else if (rdy_pct >= 100) check("one_valid_each", 64'(vld_cnt), 64'(len));
        tick();
        tick();
    endtask

    task automatic pause_test();
        logic [22:0] b;
        logic [31:0] a1;
        int c, r0;
        b = 23'h2000;
        load(b, 3, 1);
        a1 = mem[b + 23'd1];
        force_lat = 1;
        play_audio_ready = 1'b0;
        start(b);
        c = 0;
        while (c < 50 && !play_audio_valid) begin tick(); c++; end
        check("p_valid_up", 64'(play_audio_valid), 64'(1));
        check("p_data_a1", 64'(play_audio_data), 64'(a1));
        r0 = rd_cyc;
        repeat (5) tick();
        check("p_no_read_while_waiting", 64'(rd_cyc - r0), 64'(0));
        check("p_data_still_a1", 64'({play_audio_valid, play_audio_data}), 64'({1'b1, a1}));
        play_pause = 1'b1;
        play_audio_ready = 1'b1;
        tick();
        play_audio_ready = 1'b0;
        r0 = rd_cyc;
        repeat (4) tick();
        check("p_no_read_paused", 64'(rd_cyc - r0), 64'(0));
        check("p_samples_left", 64'(q_samp.size()), 64'(2));
        play_pause = 1'b0;
        play_audio_ready = 1'b1;
        c = 0;
        while (c < 100 && done_cnt == 0) begin tick(); c++; end
        play_audio_ready = 1'b0;
        finish_checks("pause");
        tick();
    endtask

    task automatic stop_test();
        logic [22:0] b;
        int c, v0;
        b = 23'h0040;
        load(b, 3, 0);
        q_addr.push_back(b + 23'd1);
        force_lat = 3;
        play_audio_ready = 1'b1;
        start(b);
        c = 0;
        while (c < 50 && !(play_read && play_addr == b + 23'd1)) begin tick(); c++; end
        check("s_fetch_seen", 64'(play_read && play_addr == b + 23'd1), 64'(1));
        tick();
        play_stop = 1'b1;
        tick();
        play_stop = 1'b0;
        check("s_read_held", 64'({play_read, play_done}), 64'({1'b1, 1'b0}));
        c = 0;
        while (c < 20 && done_cnt == 0) begin tick(); c++; end
        v0 = vld_cnt;
        repeat (5) tick();
        play_audio_ready = 1'b0;
        check("s_no_valid", 64'(vld_cnt), 64'(0));
        check("s_no_valid_after", 64'(vld_cnt - v0), 64'(0));
        finish_checks("stop");
    endtask

    task automatic reset_test();
        logic [22:0] b;
        b = 23'h1234;
        load(b, 4, 0);
        force_lat = 3;
        start(b);
        repeat (3) tick();
        check("r_mid_read", 64'(play_read), 64'(1));
        i_rst_n = 1'b0;
        tick();
        check("r_ctrl", 64'({play_done, play_read, play_write, play_audio_valid}), 64'(0));
        check("r_addr", 64'(play_addr), 64'(0));
        check("r_data", 64'({play_audio_data, play_writedata}), 64'(0));
        i_rst_n = 1'b1;
        q_addr.delete();
        tick();
    endtask

`ifdef PLAY_LOOP_EN
    task automatic loop_test();
        logic [22:0] b;
        int c;
        b = 23'h0500;
        load(b, 2, 10);
        force_lat = -1;
        play_audio_ready = 1'b1;
        start(b);
        c = 0;
        while (c < 500 && q_samp.size() > 14) begin tick(); c++; end
        check("l_six_samples", 64'(q_samp.size()), 64'(14));
        check("l_no_done", 64'(done_cnt), 64'(0));
        play_stop = 1'b1;
        c = 0;
        while (c < 20 && done_cnt == 0) begin tick(); c++; end
        play_stop = 1'b0;
        play_audio_ready = 1'b0;
        check("l_done_on_stop", 64'(done_cnt), 64'(1));
        q_addr.delete();
        q_samp.delete();
        tick();
    endtask
`endif

    initial begin
        int cyc;
        logic [22:0] rb;
        int rl;
        i_rst_n = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_ctrl", 64'({play_done, play_read, play_write, play_audio_valid}), 64'(0));
        check("rst_addr", 64'(play_addr), 64'(0));
        check("rst_data", 64'({play_audio_data, play_writedata}), 64'(0));
        i_rst_n = 1'b1;
        tick();

        run_play(23'h000100, 0, 1, 100, 0, cyc);
`ifdef PLAY_LOOP_EN
        loop_test();
`else
        run_play(23'h000100, 3, 2, 100, 0, cyc);
        run_play(23'h000200, 4, 0, 100, 0, cyc);
        check("zero_lat_cycles", 64'(cyc), 64'(2 * 4 + 1));
        run_play(23'h7FFFFF, 2, -1, 100, 0, cyc);
        pause_test();
        for (int i = 0; i < 10; i++) begin
            rb = (i % 3 == 0) ? 23'h7FFFFF - 23'($urandom_range(0, 3)) : 23'($urandom);
            rl = $urandom_range(0, 6);
            run_play(rb, rl, -1, $urandom_range(30, 100), $urandom_range(0, 50), cyc);
        end
`endif
        stop_test();
        reset_test();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
